tlul_adapter_host_mbox: RTL and testbench

- Host-side counterpart of the core-as-responder slave adapter. The Ibex core issues single TL-UL transactions through a small mailbox register window on its data interface.
- The core programs address, data and command; the block drives the A channel and collects the D response. It then raises irq_o until the core reads the response.
- Sits between the Ibex data port and a TL-UL crossbar host port.
- One outstanding transaction at a time.

---
 rtl/tlul_adapter_host_mbox_pkg.sv | 80 ++++++++
 rtl/tlul_cmd_intg_gen.sv | 14 +
 rtl/tlul_adapter_host_mbox.sv | 230 +++++++++++++++++++++++
 tb/tb_tlul_adapter_host_mbox.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_adapter_host_mbox_pkg.sv
// Shared types and constants for the host-side TL-UL mailbox adapter.
// Holds the register map, FSM states, TL-UL structs and the command-integrity function.
package tlul_adapter_host_mbox_pkg;

    localparam int unsigned TL_AW  = 32;
    localparam int unsigned TL_DW  = 32;
    localparam int unsigned TL_DBW = 4;
    localparam int unsigned TL_AIW = 8;

    localparam logic [TL_AW-1:0] MBOX_ADDR_REG   = 32'h1000_0000;
    localparam logic [TL_AW-1:0] MBOX_WDATA_REG  = 32'h1000_0004;
    localparam logic [TL_AW-1:0] MBOX_CMD_REG    = 32'h1000_0008;
    localparam logic [TL_AW-1:0] MBOX_RSP_REG    = 32'h1000_000C;
    localparam logic [TL_AW-1:0] MBOX_STATUS_REG = 32'h1000_0010;

    localparam int unsigned STATUS_BUSY     = 0;
    localparam int unsigned STATUS_RSP_PEND = 1;
    localparam int unsigned STATUS_RSP_ERR  = 2;
    localparam int unsigned STATUS_TIMEOUT  = 3;

    localparam int unsigned CMD_WE_BIT   = 0;
    localparam int unsigned CMD_MASK_LSB = 4;

    localparam logic [2:0] OpPutFullData    = 3'h0;
    localparam logic [2:0] OpPutPartialData = 3'h1;
    localparam logic [2:0] OpGet            = 3'h4;
    localparam logic [2:0] OpAccessAck      = 3'h0;
    localparam logic [2:0] OpAccessAckData  = 3'h1;

    typedef enum logic [1:0] {
        StIdle,
        StSendReq,
        StWaitRsp,
        StRspPend
    } mbox_state_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [1:0]        a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [1:0]        d_size;
        logic [TL_AIW-1:0] d_source;
        logic              d_sink;
        logic [TL_DW-1:0]  d_data;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    // Folds opcode, address and mask into a 7-bit check word.
    function automatic logic [6:0] cmd_intg_calc(logic [2:0] op, logic [TL_AW-1:0] addr,
                                                 logic [TL_DBW-1:0] mask);
        logic [38:0] v;
        logic [6:0]  r;
        v = {op, addr, mask};
        r = '0;
        for (int i = 0; i < 39; i++) begin
            r[i % 7] = r[i % 7] ^ v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tlul_cmd_intg_gen.sv
// Appends command integrity to an outgoing TL-UL A-channel struct.
module tlul_cmd_intg_gen
    import tlul_adapter_host_mbox_pkg::*;
(
    input  tl_h2d_t tl_i,
    output tl_h2d_t tl_o
);

    always_comb begin
        tl_o = tl_i;
        tl_o.a_user.cmd_intg = cmd_intg_calc(tl_i.a_opcode, tl_i.a_address, tl_i.a_mask);
    end

endmodule

// File: rtl/tlul_adapter_host_mbox.sv
// Core-programmed TL-UL host mailbox: one outstanding transaction, irq until response read.
// Optional response timeout and late-beat drain under TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN.
module tlul_adapter_host_mbox
    import tlul_adapter_host_mbox_pkg::*;
#(
    parameter int unsigned SrcW          = TL_AIW,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [TL_AW-1:0]  addr_i,
    input  logic              we_i,
    input  logic [TL_DW-1:0]  wdata_i,
    input  logic [TL_DBW-1:0] be_i,
    output logic              valid_o,
    output logic [TL_DW-1:0]  rdata_o,
    output logic              err_o,
    output logic              irq_o,
    output tl_h2d_t           tl_o,
    input  tl_d2h_t           tl_i
);

    mbox_state_e state_q, state_d;
    logic [TL_AW-1:0] addr_q, addr_d;
    logic [TL_DW-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d, rdata_q, rdata_d;
    logic [3:0]       mask_q, mask_d;
    logic [SrcW-1:0]  src_q, src_d;
    logic             we_q, we_d, rsp_err_q, rsp_err_d, valid_q, valid_d, err_q, err_d;
    logic             idle, tmo_flag, d_ready;
    logic [TL_DW-1:0] status, cap_data;
    logic             cap_err;
    tl_h2d_t          tl_raw;

`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
    logic        tmo_flag_q, tmo_flag_d, drain_q, drain_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    assign tmo_flag = tmo_flag_q;
    // Drain keeps accepting so an abandoned beat cannot stall the crossbar.
    assign d_ready  = (state_q == StWaitRsp) || (drain_q && state_q != StSendReq);
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TimeoutCycles;
    assign tmo_flag   = 1'b0;
    assign d_ready    = (state_q == StWaitRsp);
`endif

    logic unused_sig;
    assign unused_sig = ^{be_i, tl_i.d_param, tl_i.d_size, tl_i.d_sink};

    assign idle = (state_q == StIdle);

    always_comb begin
        status = '0;
        status[STATUS_BUSY]     = (state_q == StSendReq) || (state_q == StWaitRsp);
        status[STATUS_RSP_PEND] = (state_q == StRspPend);
        status[STATUS_RSP_ERR]  = rsp_err_q;
        status[STATUS_TIMEOUT]  = tmo_flag;
    end

    // Issued source is one behind the counter once the A beat has been accepted.
    assign cap_data = (tl_i.d_opcode == OpAccessAckData) ? tl_i.d_data : '0;
    assign cap_err  = tl_i.d_error
                    || (tl_i.d_source != TL_AIW'(src_q - 1'b1))
                    || (tl_i.d_opcode != (we_q ? OpAccessAck : OpAccessAckData));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        mask_d     = mask_q;
        src_d      = src_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
        tmo_flag_d = tmo_flag_q;
        drain_d    = drain_q;
        tmo_cnt_d  = tmo_cnt_q;
`endif
        valid_d = req_i;
        rdata_d = '0;
        err_d   = 1'b0;

        if (req_i) begin
            if (addr_i == MBOX_ADDR_REG) begin
                if (!we_i)     rdata_d = addr_q;
                else if (idle) addr_d  = wdata_i;
                else           err_d   = 1'b1;
            end else if (addr_i == MBOX_WDATA_REG) begin
                if (!we_i)     rdata_d = wdata_q;
                else if (idle) wdata_d = wdata_i;
                else           err_d   = 1'b1;
            end else if (addr_i == MBOX_CMD_REG) begin
                if (we_i && idle) begin
                    we_d       = wdata_i[CMD_WE_BIT];
                    mask_d     = wdata_i[CMD_MASK_LSB +: 4];
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = StSendReq;
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
                    tmo_flag_d = 1'b0;
`endif
                end else if (we_i) begin
                    err_d = 1'b1;
                end
            end else if (addr_i == MBOX_RSP_REG) begin
                if (!we_i && state_q == StRspPend) begin
                    rdata_d = rsp_data_q;
                    state_d = StIdle;
                end else begin
                    err_d = 1'b1;
                end
            end else if (addr_i == MBOX_STATUS_REG && !we_i) begin
                rdata_d = status;
            end else begin
                err_d = 1'b1;
            end
        end

        unique case (state_q)
            StSendReq: begin
                if (tl_i.a_ready) begin
                    state_d = StWaitRsp;
                    src_d   = src_q + 1'b1;
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end
            end
            StWaitRsp: begin
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
                if (tl_i.d_valid && drain_q) begin
                    drain_d = 1'b0;
                end else if (tl_i.d_valid) begin
                    state_d    = StRspPend;
                    rsp_data_d = cap_data;
                    rsp_err_d  = cap_err;
                end else if (tmo_cnt_q == TimeoutCycles - 1) begin
                    state_d    = StRspPend;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    tmo_flag_d = 1'b1;
                    drain_d    = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1;
                end
`else
                if (tl_i.d_valid) begin
                    state_d    = StRspPend;
                    rsp_data_d = cap_data;
                    rsp_err_d  = cap_err;
                end
`endif
            end
            default: begin
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
                if (drain_q && tl_i.d_valid && state_q != StSendReq) drain_d = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            mask_q     <= '0;
            src_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
            tmo_flag_q <= 1'b0;
            drain_q    <= 1'b0;
            tmo_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            mask_q     <= mask_d;
            src_q      <= src_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            valid_q    <= valid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
            tmo_flag_q <= tmo_flag_d;
            drain_q    <= drain_d;
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    // A fields are zero outside SEND_REQ so the bus is quiet when idle.
    always_comb begin
        tl_raw = '0;
        if (state_q == StSendReq) begin
            tl_raw.a_valid   = 1'b1;
            tl_raw.a_opcode  = !we_q ? OpGet : (mask_q == 4'hF) ? OpPutFullData
                                                                 : OpPutPartialData;
            tl_raw.a_size    = 2'd2;
            tl_raw.a_source  = TL_AIW'(src_q);
            tl_raw.a_address = {addr_q[TL_AW-1:2], 2'b00};
            tl_raw.a_mask    = we_q ? mask_q : 4'hF;
            tl_raw.a_data    = wdata_q;
        end
        tl_raw.d_ready = d_ready;
    end

    tlul_cmd_intg_gen u_intg (
        .tl_i (tl_raw),
        .tl_o (tl_o)
    );

    assign gnt_o   = req_i;
    assign valid_o = valid_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign irq_o   = (state_q == StRspPend);

endmodule

// File: tb/tb_tlul_adapter_host_mbox.sv
// Directed self-checking bench for tlul_adapter_host_mbox (timeout steps run only with
// TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN defined).
module tb_tlul_adapter_host_mbox;
    import tlul_adapter_host_mbox_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = 4'hF;
    logic        gnt, valid, err, irq;
    logic [31:0] rdata;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d = '0;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    tlul_adapter_host_mbox #(.SrcW(8), .TimeoutCycles(16)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req_i   (req),
        .gnt_o   (gnt),
        .addr_i  (addr),
        .we_i    (we),
        .wdata_i (wdata),
        .be_i    (be),
        .valid_o (valid),
        .rdata_o (rdata),
        .err_o   (err),
        .irq_o   (irq),
        .tl_o    (tl_h),
        .tl_i    (tl_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic core_acc(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1 chk("gnt", 32'(gnt), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'b0;
        chk("valid", 32'(valid), 32'd1);
        rd = rdata; e = err;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err);
        logic [31:0] rd;
        logic e;
        core_acc(1'b1, a, d, rd, e);
        chk(tag, 32'(e), 32'(exp_err));
    endtask

    task automatic rdchk(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_err);
        logic [31:0] rd;
        logic e;
        core_acc(1'b0, a, '0, rd, e);
        chk(tag, rd, exp_d);
        chk({tag, "_err"}, 32'(e), 32'(exp_err));
    endtask

    task automatic accept();
        @(negedge clk);
        tl_d.a_ready = 1'b1;
        @(posedge clk);
        #1 tl_d.a_ready = 1'b0;
    endtask

    task automatic d_beat(input logic [2:0] op, input logic [31:0] data, input logic [7:0] src,
                          input logic derr);
        @(negedge clk);
        tl_d.d_valid = 1'b1; tl_d.d_opcode = op; tl_d.d_data = data;
        tl_d.d_source = src; tl_d.d_error = derr;
        @(posedge clk);
        #1 tl_d.d_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_a_valid", 32'(tl_h.a_valid), 32'd0);
        chk("rst_d_ready", 32'(tl_h.d_ready), 32'd0);
        chk("rst_a_addr", tl_h.a_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rdchk("rst_status", MBOX_STATUS_REG, 32'h0, 1'b0);

        // PutFullData with low address bits masked
        wr("w_addr", MBOX_ADDR_REG, 32'h4000_0013, 1'b0);
        wr("w_wdata", MBOX_WDATA_REG, 32'hDEAD_BEEF, 1'b0);
        rdchk("r_addr", MBOX_ADDR_REG, 32'h4000_0013, 1'b0);
        wr("w_cmd1", MBOX_CMD_REG, 32'hF1, 1'b0);
        chk("t1_op", 32'(tl_h.a_opcode), 32'(OpPutFullData));
        chk("t1_addr", tl_h.a_address, 32'h4000_0010);
        chk("t1_mask", 32'(tl_h.a_mask), 32'hF);
        chk("t1_src", 32'(tl_h.a_source), 32'h0);
        chk("t1_data", tl_h.a_data, 32'hDEAD_BEEF);
        chk("t1_size", 32'(tl_h.a_size), 32'd2);
        rdchk("t1_status_busy", MBOX_STATUS_REG, 32'h1, 1'b0);
        accept();
        chk("t1_a_valid_off", 32'(tl_h.a_valid), 32'd0);
        chk("t1_d_ready", 32'(tl_h.d_ready), 32'd1);
        d_beat(OpAccessAck, 32'h0, 8'h00, 1'b0);
        chk("t1_irq", 32'(irq), 32'd1);
        rdchk("t1_status_pend", MBOX_STATUS_REG, 32'h2, 1'b0);
        rdchk("t1_rsp", MBOX_RSP_REG, 32'h0, 1'b0);
        chk("t1_irq_drop", 32'(irq), 32'd0);
        rdchk("t1_status_done", MBOX_STATUS_REG, 32'h0, 1'b0);

        // Get held off by a_ready for 5 cycles
        wr("w_addr2", MBOX_ADDR_REG, 32'h4000_0020, 1'b0);
        wr("w_cmd2", MBOX_CMD_REG, 32'h00, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("t2_hold_valid", 32'(tl_h.a_valid), 32'd1);
            chk("t2_hold_op", 32'(tl_h.a_opcode), 32'(OpGet));
            chk("t2_hold_addr", tl_h.a_address, 32'h4000_0020);
            chk("t2_hold_mask", 32'(tl_h.a_mask), 32'hF);
            chk("t2_hold_src", 32'(tl_h.a_source), 32'h1);
        end
        accept();
        d_beat(OpAccessAckData, 32'h1234_5678, 8'h01, 1'b0);
        rdchk("t2_rsp", MBOX_RSP_REG, 32'h1234_5678, 1'b0);

        // PutPartialData with d_error
        wr("w_cmd3", MBOX_CMD_REG, 32'h31, 1'b0);
        chk("t3_op", 32'(tl_h.a_opcode), 32'(OpPutPartialData));
        chk("t3_mask", 32'(tl_h.a_mask), 32'h3);
        accept();
        d_beat(OpAccessAck, 32'h0, 8'h02, 1'b1);
        rdchk("t3_status", MBOX_STATUS_REG, 32'h6, 1'b0);
        rdchk("t3_rsp", MBOX_RSP_REG, 32'h0, 1'b0);

        // Error accesses while busy, unmapped, and RSP with nothing pending
        wr("w_cmd4", MBOX_CMD_REG, 32'h00, 1'b0);
        wr("busy_cmd", MBOX_CMD_REG, 32'h01, 1'b1);
        wr("busy_addr", MBOX_ADDR_REG, 32'h5000_0000, 1'b1);
        chk("busy_op_kept", 32'(tl_h.a_opcode), 32'(OpGet));
        chk("busy_addr_kept", tl_h.a_address, 32'h4000_0020);
        rdchk("unmapped", 32'h1000_0100, 32'h0, 1'b1);
        accept();
        rdchk("rsp_none", MBOX_RSP_REG, 32'h0, 1'b1);
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = MBOX_RSP_REG;
        tl_d.d_valid = 1'b1; tl_d.d_opcode = OpAccessAckData; tl_d.d_data = 32'hAAAA_5555;
        tl_d.d_source = 8'h03; tl_d.d_error = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0; tl_d.d_valid = 1'b0;
        chk("same_cycle_err", 32'(err), 32'd1);
        chk("same_cycle_rdata", rdata, 32'h0);
        chk("same_cycle_irq", 32'(irq), 32'd1);
        rdchk("t4_rsp", MBOX_RSP_REG, 32'hAAAA_5555, 1'b0);

        // Mismatched d_source
        wr("w_cmd5", MBOX_CMD_REG, 32'h00, 1'b0);
        chk("t5_src", 32'(tl_h.a_source), 32'h4);
        accept();
        d_beat(OpAccessAckData, 32'h0000_0009, 8'h09, 1'b0);
        rdchk("t5_status", MBOX_STATUS_REG, 32'h6, 1'b0);
        rdchk("t5_rsp", MBOX_RSP_REG, 32'h9, 1'b0);

        // Source counter wraps 0xFF -> 0x00
        for (int s = 5; s <= 256; s++) begin
            wr("wrap_cmd", MBOX_CMD_REG, 32'h00, 1'b0);
            chk("wrap_src", 32'(tl_h.a_source), 32'(s % 256));
            accept();
            d_beat(OpAccessAckData, 32'(s), 8'(s % 256), 1'b0);
            rdchk("wrap_status", MBOX_STATUS_REG, 32'h2, 1'b0);
            rdchk("wrap_rsp", MBOX_RSP_REG, 32'(s), 1'b0);
        end

        // Reset during SEND_REQ, then a late D beat
        wr("w_cmd6", MBOX_CMD_REG, 32'h00, 1'b0);
        chk("r6_a_valid", 32'(tl_h.a_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("r6_a_valid_rst", 32'(tl_h.a_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("r6_d_ready", 32'(tl_h.d_ready), 32'd0);
        d_beat(OpAccessAckData, 32'hCAFE_0000, 8'h01, 1'b0);
        chk("r6_irq", 32'(irq), 32'd0);
        rdchk("r6_status", MBOX_STATUS_REG, 32'h0, 1'b0);
        wr("w_cmd7", MBOX_CMD_REG, 32'h00, 1'b0);
        chk("r6_src_reset", 32'(tl_h.a_source), 32'h0);
        chk("r6_addr_reset", tl_h.a_address, 32'h0);
        accept();
        d_beat(OpAccessAckData, 32'h0000_0077, 8'h00, 1'b0);
        rdchk("r6_rsp", MBOX_RSP_REG, 32'h77, 1'b0);

`ifdef TLUL_ADAPTER_HOST_MBOX_TIMEOUT_EN
        // Timeout after 16 WAIT_RSP cycles, then drain a late beat
        wr("w_cmd8", MBOX_CMD_REG, 32'h00, 1'b0);
        accept();
        for (int k = 0; k < 15; k++) @(posedge clk);
        #1 chk("tmo_irq_early", 32'(irq), 32'd0);
        @(posedge clk);
        #1 chk("tmo_irq", 32'(irq), 32'd1);
        chk("tmo_d_ready_pend", 32'(tl_h.d_ready), 32'd1);
        rdchk("tmo_status", MBOX_STATUS_REG, 32'hE, 1'b0);
        rdchk("tmo_rsp", MBOX_RSP_REG, 32'h0, 1'b0);
        chk("tmo_d_ready_idle", 32'(tl_h.d_ready), 32'd1);
        d_beat(OpAccessAckData, 32'h5555_AAAA, 8'h01, 1'b0);
        chk("tmo_drained", 32'(tl_h.d_ready), 32'd0);
        chk("tmo_irq_after", 32'(irq), 32'd0);
        rdchk("tmo_status_after", MBOX_STATUS_REG, 32'hC, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
